// File: rtl/fft_seq_ctrl.sv
// rtl/fft_seq_ctrl.sv - FFT load/calculate/export sequencer driving a radix-2 butterfly unit.
// Optional inverse-transform op (op_sel=3) enabled by defining FFT_IFFT_EN.
module fft_seq_ctrl #(
    parameter int N_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [1:0]        op_sel,
    output logic              op_ready,
    output logic              stall,
    output logic              ram_we,
    output logic [N_LOG2-1:0] ram_waddr,
    output logic [N_LOG2-1:0] ram_raddr,
    output logic              bf_start,
    output logic [N_LOG2-1:0] bf_addr_a,
    output logic [N_LOG2-1:0] bf_addr_b,
    output logic [N_LOG2-2:0] bf_tw_idx,
    output logic              bf_inv,
    input  logic              bf_done,
    output logic              done,
    output logic              busy,
    output logic              err
);

    localparam int SW = $clog2(N_LOG2);
    localparam logic [N_LOG2-2:0] M_LAST = '1;
    localparam logic [SW-1:0]     S_LAST = SW'(N_LOG2 - 1);
    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_CAL  = 2'd1;
    localparam logic [1:0] OP_EXP  = 2'd2;
    localparam logic [1:0] OP_ICAL = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [N_LOG2-1:0] load_cnt_q, load_cnt_d;
    logic [N_LOG2-1:0] exp_cnt_q, exp_cnt_d;
    logic [SW-1:0]     stage_q, stage_d;
    logic [N_LOG2-2:0] m_q, m_d;
    logic              full_q, full_d;
    logic              computed_q, computed_d;
    logic              err_q, err_d;
`ifdef FFT_IFFT_EN
    logic              inv_q, inv_d;
`endif

    logic              accept;
    logic              active;
    logic [N_LOG2-1:0] m_ext, half_w, k_w, grp_w, a_w;
    logic [N_LOG2-2:0] tw_w;
    int unsigned       s_i;

    // Butterfly indices: m enumerates pairs; low s bits pick the offset, the rest the group.
    always_comb begin
        s_i    = 32'(stage_q);
        m_ext  = {1'b0, m_q};
        half_w = N_LOG2'(1) << s_i;
        k_w    = m_ext & (half_w - N_LOG2'(1));
        grp_w  = m_ext >> s_i;
        a_w    = (grp_w << (s_i + 1)) | k_w;
        tw_w   = k_w[N_LOG2-2:0] << (N_LOG2 - 1 - s_i);
    end

    always_comb begin
        ram_waddr = '0;
        for (int i = 0; i < N_LOG2; i++) begin
            ram_waddr[i] = load_cnt_q[N_LOG2-1-i];
        end
    end

    assign op_ready  = (state_q == S_IDLE);
    assign active    = ~op_ready;
    assign stall     = active;
    assign busy      = active;
    assign accept    = op_valid & op_ready;
    assign ram_we    = accept & (op_sel == OP_LOAD);
    assign ram_raddr = exp_cnt_q;
    assign err       = err_q;
    assign bf_addr_a = active ? a_w : '0;
    assign bf_addr_b = active ? (a_w | half_w) : '0;
    assign bf_tw_idx = active ? tw_w : '0;
`ifdef FFT_IFFT_EN
    assign bf_inv    = inv_q & active;
`else
    assign bf_inv    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        exp_cnt_d  = exp_cnt_q;
        stage_d    = stage_q;
        m_d        = m_q;
        full_d     = full_q;
        computed_d = computed_q;
        err_d      = err_q;
`ifdef FFT_IFFT_EN
        inv_d      = inv_q;
`endif
        bf_start   = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op_sel)
                        OP_LOAD: begin
                            load_cnt_d = load_cnt_q + N_LOG2'(1);
                            if (full_q) begin
                                full_d     = 1'b0;
                                computed_d = 1'b0;
                            end else if (load_cnt_q == '1) begin
                                full_d = 1'b1;
                            end
                        end
                        OP_CAL: begin
                            if (!full_q) begin
                                err_d = 1'b1;
                            end else begin
                                stage_d = '0;
                                m_d     = '0;
                                state_d = S_ISSUE;
`ifdef FFT_IFFT_EN
                                inv_d   = 1'b0;
`endif
                            end
                        end
                        OP_EXP: begin
                            exp_cnt_d = exp_cnt_q + N_LOG2'(1);
                            if (!computed_q) begin
                                err_d = 1'b1;
                            end
                        end
                        OP_ICAL: begin
`ifdef FFT_IFFT_EN
                            if (!full_q) begin
                                err_d = 1'b1;
                            end else begin
                                stage_d = '0;
                                m_d     = '0;
                                state_d = S_ISSUE;
                                inv_d   = 1'b1;
                            end
`else
                            err_d = 1'b1;
`endif
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_ISSUE: begin
                bf_start = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (bf_done) begin
                    if (m_q != M_LAST) begin
                        m_d     = m_q + 1'b1;
                        state_d = S_ISSUE;
                    end else if (stage_q != S_LAST) begin
                        m_d     = '0;
                        stage_d = stage_q + 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        done       = 1'b1;
                        computed_d = 1'b1;
                        exp_cnt_d  = '0;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            load_cnt_q <= '0;
            exp_cnt_q  <= '0;
            stage_q    <= '0;
            m_q        <= '0;
            full_q     <= 1'b0;
            computed_q <= 1'b0;
            err_q      <= 1'b0;
`ifdef FFT_IFFT_EN
            inv_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            exp_cnt_q  <= exp_cnt_d;
            stage_q    <= stage_d;
            m_q        <= m_d;
            full_q     <= full_d;
            computed_q <= computed_d;
            err_q      <= err_d;
`ifdef FFT_IFFT_EN
            inv_q      <= inv_d;
`endif
        end
    end

endmodule
